mmio_gpio_responder: RTL and testbench

- Memory-mapped peripheral that answers load/store requests from the multi-cycle MIPS core's data port. It is the responder end of the core's GPIO interface.
- Owns the 8-bit output register that drives the GPIO pins.
- Synchronises and debounces the 8 GPIO input pins, and latches rising edges in sticky W1C flags for software polling.
- Sits between the core's data-memory decode and the board pins; replaces the direct GPIO wiring.

---
 rtl/mmio_gpio_responder.sv | 143 ++++++++++++++
 tb/tb_mmio_gpio_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_gpio_responder.sv
// mmio_gpio_responder
//   Memory-mapped GPIO responder for the multi-cycle MIPS data port.
//   Owns the 8-bit output register driving the pins. Synchronises and
//   debounces the 8 input pins. Latches debounced rising edges in sticky,
//   write-1-to-clear flags that software polls.
//
//   Register window (16 bytes at BASE_ADDR, offset = Addr[3:2]):
//     0 OUT  RW  [7:0]
//     1 IN   RO  [7:0] debounced inputs
//     2 EDGE W1C [7:0] sticky rising-edge flags
//     3 THR  RW  [CNT_WIDTH-1:0] debounce threshold (CNT_WIDTH <= 32)
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   Req        one-cycle access request
//   Mem_Write  1 = store, 0 = load (sampled with Req)
//   Addr       byte address (sampled with Req)
//   Wr_Data    store data (sampled with Req)
//   Ack        response pulse, one cycle after each Req
//   Rd_Data    load data while Ack=1, otherwise 0
//   GPIO_i     asynchronous input pins
//   GPIO_o     output pins (OUT register)
module mmio_gpio_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned DEB_RESET = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        Mem_Write,
  input  logic [31:0] Addr,
  input  logic [31:0] Wr_Data,
  output logic        Ack,
  output logic [31:0] Rd_Data,
  input  logic [7:0]  GPIO_i,
  output logic [7:0]  GPIO_o
);

  typedef enum logic [1:0] {
    REG_OUT  = 2'd0,
    REG_IN   = 2'd1,
    REG_EDGE = 2'd2,
    REG_THR  = 2'd3
  } reg_sel_t;

  reg_sel_t             sel;
  logic                 hit;
  logic                 rd_en;
  logic                 wr_en;
  logic [31:0]          rd_val;

  logic [7:0]           out_q;
  logic [7:0]           s1_q;
  logic [7:0]           s2_q;
  logic [7:0]           in_q;
  logic [7:0]           in_next;
  logic [7:0]           edge_q;
  logic [7:0]           edge_next;
  logic [7:0]           edge_clr;
  logic [CNT_WIDTH-1:0] thr_q;
  logic [CNT_WIDTH-1:0] cnt_q    [8];
  logic [CNT_WIDTH-1:0] cnt_next [8];

  logic                 ack_q;
  logic [31:0]          rd_q;

  // Address low bits and upper store-data bits have no function.
  logic                 unused_bits;
  assign unused_bits = ^{Addr[1:0], Wr_Data};

  assign sel   = reg_sel_t'(Addr[3:2]);
  assign hit   = (Addr[31:4] == BASE_ADDR[31:4]);
  assign rd_en = Req && hit && !Mem_Write;
  assign wr_en = Req && hit && Mem_Write;

  // Read mux uses the pre-edge register values.
  always_comb begin
    rd_val = '0;
    unique case (sel)
      REG_OUT:  rd_val = {24'h0, out_q};
      REG_IN:   rd_val = {24'h0, in_q};
      REG_EDGE: rd_val = {24'h0, edge_q};
      REG_THR:  rd_val = 32'(thr_q);
    endcase
  end

  // Per-bit debounce: a mismatch between the synchronised input and IN must
  // persist for THR+1 edges before IN follows. The counter saturates so a
  // threshold lowered below a running count cannot make it wrap and fire.
  always_comb begin
    in_next = in_q;
    for (int unsigned i = 0; i < 8; i++) begin
      cnt_next[i] = cnt_q[i];
      if (s2_q[i] == in_q[i]) begin
        cnt_next[i] = '0;
      end else if (cnt_q[i] == thr_q) begin
        in_next[i]  = s2_q[i];
        cnt_next[i] = '0;
      end else if (cnt_q[i] != '1) begin
        cnt_next[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  // A new rising edge wins over a W1C clear of the same bit on the same edge.
  always_comb begin
    edge_clr  = (wr_en && sel == REG_EDGE) ? Wr_Data[7:0] : '0;
    edge_next = (edge_q & ~edge_clr) | (in_next & ~in_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      in_q   <= '0;
      edge_q <= '0;
      thr_q  <= CNT_WIDTH'(DEB_RESET);
      cnt_q  <= '{default: '0};
      ack_q  <= 1'b0;
      rd_q   <= '0;
    end else begin
      s1_q   <= GPIO_i;
      s2_q   <= s1_q;
      in_q   <= in_next;
      cnt_q  <= cnt_next;
      edge_q <= edge_next;
      ack_q  <= Req;
      rd_q   <= rd_en ? rd_val : '0;
      if (wr_en) begin
        if (sel == REG_OUT) out_q <= Wr_Data[7:0];
        if (sel == REG_THR) thr_q <= Wr_Data[CNT_WIDTH-1:0];
      end
    end
  end

  assign Ack     = ack_q;
  assign Rd_Data = rd_q;
  assign GPIO_o  = out_q;

endmodule

// File: tb/tb_mmio_gpio_responder.sv
// Directed bench for mmio_gpio_responder with a spec-level reference model
// compared against Ack, Rd_Data and GPIO_o on every falling edge.
module tb_mmio_gpio_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic        Mem_Write;
  logic [31:0] Addr;
  logic [31:0] Wr_Data;
  logic        Ack;
  logic [31:0] Rd_Data;
  logic [7:0]  GPIO_i;
  logic [7:0]  GPIO_o;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;

  mmio_gpio_responder #(
    .BASE_ADDR(BASE),
    .CNT_WIDTH(16),
    .DEB_RESET(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Req(Req),
    .Mem_Write(Mem_Write),
    .Addr(Addr),
    .Wr_Data(Wr_Data),
    .Ack(Ack),
    .Rd_Data(Rd_Data),
    .GPIO_i(GPIO_i),
    .GPIO_o(GPIO_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [7:0]  m_out, m_in, m_edge, m_new_in, m_clr, v;
  int unsigned m_thr;
  int unsigned run [8];
  logic [7:0]  smp_q [$] = '{8'h00, 8'h00};
  logic        exp_ack;
  logic [31:0] exp_rd;

  always @(posedge clk) begin
    if (reset) begin
      m_out = 0; m_in = 0; m_edge = 0; m_thr = 4;
      foreach (run[i]) run[i] = 0;
      smp_q = '{8'h00, 8'h00};
      exp_ack = 0; exp_rd = 0;
    end else begin
      // response from state as it stood before this edge
      exp_ack = Req;
      exp_rd  = 0;
      if (Req && !Mem_Write && Addr[31:4] == BASE[31:4]) begin
        case (Addr[3:2])
          2'd0: exp_rd = {24'h0, m_out};
          2'd1: exp_rd = {24'h0, m_in};
          2'd2: exp_rd = {24'h0, m_edge};
          default: exp_rd = m_thr;
        endcase
      end
      // pin value seen through two sampling stages
      v = smp_q.pop_front();
      smp_q.push_back(GPIO_i);
      m_new_in = m_in;
      for (int i = 0; i < 8; i++) begin
        if (v[i] == m_in[i]) run[i] = 0;
        else begin
          run[i]++;
          if (run[i] == m_thr + 1) begin
            m_new_in[i] = v[i];
            run[i] = 0;
          end
        end
      end
      m_clr = 0;
      if (Req && Mem_Write && Addr[31:4] == BASE[31:4]) begin
        case (Addr[3:2])
          2'd0: m_out = Wr_Data[7:0];
          2'd2: m_clr = Wr_Data[7:0];
          2'd3: m_thr = Wr_Data[15:0];
          default: ;
        endcase
      end
      m_edge = (m_edge & ~m_clr) | (m_new_in & ~m_in);
      m_in   = m_new_in;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      vectors++;
      if (Ack !== exp_ack || Rd_Data !== exp_rd || GPIO_o !== m_out) begin
        miscompares++;
        $display("FAIL model t=%0t: Ack=%b Rd_Data=%h GPIO_o=%h, required Ack=%b Rd_Data=%h GPIO_o=%h",
                 $time, Ack, Rd_Data, GPIO_o, exp_ack, exp_rd, m_out);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end
  endtask

  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d);
    Req = 1'b1; Mem_Write = wr; Addr = a; Wr_Data = d;
    tick();
    Req = 1'b0; Mem_Write = 1'b0;
  endtask

  task automatic load_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    access(1'b0, a, 32'h0);
    check({nm, "_ack"}, {31'h0, Ack}, 32'h1);
    check(nm, Rd_Data, exp);
  endtask

  initial begin
    reset = 1'b1; Req = 1'b0; Mem_Write = 1'b0; Addr = '0; Wr_Data = '0; GPIO_i = '0;
    idle(2);
    reset = 1'b0;
    armed = 1'b1;

    check("rst_gpio_o", {24'h0, GPIO_o}, 32'h0);
    check("rst_ack", {31'h0, Ack}, 32'h0);
    check("rst_rd", Rd_Data, 32'h0);
    load_chk("rst_thr", BASE + 32'hC, 32'h4);

    access(1'b1, BASE, 32'hFFFF_FFA5);
    check("out_pins", {24'h0, GPIO_o}, 32'hA5);
    load_chk("out_read", BASE, 32'h0000_00A5);

    // debounce with THR=4: IN follows at edge 7 after the pin change
    access(1'b1, BASE + 32'hC, 32'h4);
    GPIO_i = 8'h01;
    idle(6);
    load_chk("in_before_edge7", BASE + 32'h4, 32'h00);
    load_chk("in_after_edge7", BASE + 32'h4, 32'h01);

    // three-cycle glitch on bit 1 is filtered
    GPIO_i = 8'h03;
    idle(3);
    GPIO_i = 8'h01;
    idle(10);
    load_chk("glitch_in", BASE + 32'h4, 32'h01);
    load_chk("glitch_edge", BASE + 32'h8, 32'h01);

    // W1C of bit 0 on the same edge IN[2] rises
    GPIO_i = 8'h05;
    idle(6);
    access(1'b1, BASE + 32'h8, 32'h1);
    load_chk("w1c_edge", BASE + 32'h8, 32'h04);

    // clear of bit 3 collides with its own rise: set wins
    GPIO_i = 8'h0D;
    idle(6);
    access(1'b1, BASE + 32'h8, 32'h0C);
    load_chk("setwins_edge", BASE + 32'h8, 32'h08);

    // falling input updates IN but not EDGE
    GPIO_i = 8'h0C;
    idle(8);
    load_chk("fall_in", BASE + 32'h4, 32'h0C);
    load_chk("fall_edge", BASE + 32'h8, 32'h08);

    // THR=0: change visible in IN at edge 3
    access(1'b1, BASE + 32'hC, 32'h0);
    GPIO_i = 8'h1C;
    idle(2);
    load_chk("thr0_before", BASE + 32'h4, 32'h0C);
    load_chk("thr0_after", BASE + 32'h4, 32'h1C);

    // back-to-back requests, including a miss just past the window
    load_chk("b2b_out", BASE, 32'hA5);
    load_chk("b2b_in", BASE + 32'h4, 32'h1C);
    load_chk("b2b_miss", BASE + 32'h10, 32'h0);
    load_chk("byte_offset_ignored", BASE + 32'h3, 32'hA5);
    access(1'b1, 32'h2000_0000, 32'hFF);
    check("miss_store_pins", {24'h0, GPIO_o}, 32'hA5);

    // reset coinciding with a store: no Ack, nothing written
    GPIO_i = 8'h00;
    Req = 1'b1; Mem_Write = 1'b1; Addr = BASE; Wr_Data = 32'h33; reset = 1'b1;
    tick();
    Req = 1'b0; Mem_Write = 1'b0; reset = 1'b0;
    check("rstacc_ack", {31'h0, Ack}, 32'h0);
    check("rstacc_pins", {24'h0, GPIO_o}, 32'h0);
    idle(1);
    load_chk("rstacc_thr", BASE + 32'hC, 32'h4);
    load_chk("rstacc_in", BASE + 32'h4, 32'h0);
    load_chk("rstacc_edge", BASE + 32'h8, 32'h0);

    idle(2);
    armed = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
